// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment checks, store lane replication, load extension,
// and an SRAM-like req/addr_ok/data_ok bus master that stalls the pipeline until the access completes.
module mem_stage_lsu #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [2:0]  memopM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        pipe_stallM,
    input  logic        flushM,
    output logic [31:0] readdataM,
    output logic        stall_reqM,
    output logic        adelM,
    output logic        adesM,
    output logic        bus_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE, CANCEL} state_t;

    state_t        state, nextState;
    logic [CW-1:0] waitCnt;
    logic [31:0]   resultReg;
    logic [31:0]   loadVal;
    logic [7:0]    byteVal;
    logic [15:0]   halfVal;
    logic          isStore, isHalf, isWord, misaligned, acc, expired, capture;

    assign isStore    = memopM[2] & (memopM[1:0] != 2'b00);
    assign isWord     = (memopM == 3'b100) | (memopM == 3'b111);
    assign isHalf     = (memopM[2:1] == 2'b01) | (memopM == 3'b110);
    assign misaligned = isWord ? (addrM[1:0] != 2'b00) : (isHalf & addrM[0]);
    assign adelM      = memenM & ~isStore & misaligned;
    assign adesM      = memenM & isStore & misaligned;
    assign acc        = memenM & ~flushM & ~adelM & ~adesM;
    assign expired    = (waitCnt == CW'(MAX_WAIT));

    assign byteVal = data_rdata[{addrM[1:0], 3'b000} +: 8];
    assign halfVal = data_rdata[{addrM[1], 4'b0000} +: 16];

    always_comb begin
        case (memopM)
            3'b000:  loadVal = {{24{byteVal[7]}}, byteVal};
            3'b001:  loadVal = {24'b0, byteVal};
            3'b010:  loadVal = {{16{halfVal[15]}}, halfVal};
            3'b011:  loadVal = {16'b0, halfVal};
            3'b100:  loadVal = data_rdata;
            default: loadVal = '0;
        endcase
    end

    // Bus handshake: data_req with addr/size/wr/wdata is a request held stable until a cycle
    // with data_addr_ok accepts it; each accepted request gets exactly one data_data_ok later.
    assign data_wr   = data_req & isStore;
    assign data_size = data_req ? (isWord ? 2'd2 : (isHalf ? 2'd1 : 2'd0)) : 2'd0;
    assign data_addr = data_req ? addrM : '0;

    always_comb begin
        data_wdata = '0;
        if (data_req) begin
            case (memopM)
                3'b101:  data_wdata = {4{wdataM[7:0]}};
                3'b110:  data_wdata = {2{wdataM[15:0]}};
                default: data_wdata = wdataM;
            endcase
        end
    end

    always_comb begin
        nextState  = state;
        data_req   = 1'b0;
        stall_reqM = 1'b0;
        bus_err    = 1'b0;
        readdataM  = '0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                data_req   = acc;
                stall_reqM = acc;
                if (acc) nextState = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
            end
            WAIT_ADDR: begin
                data_req   = 1'b1;
                stall_reqM = 1'b1;
                if (flushM) begin
                    nextState = data_addr_ok ? CANCEL : IDLE;
                end else if (data_addr_ok) begin
                    nextState = WAIT_DATA;
                end else if (expired) begin
                    bus_err   = 1'b1;
                    nextState = IDLE;
                end
            end
            WAIT_DATA: begin
                if (data_data_ok) begin
                    capture   = 1'b1;
                    readdataM = loadVal;
                    nextState = (pipe_stallM & ~flushM) ? DONE : IDLE;
                end else begin
                    stall_reqM = 1'b1;
                    if (flushM) begin
                        nextState = CANCEL;
                    end else if (expired) begin
                        bus_err   = 1'b1;
                        nextState = CANCEL;
                    end
                end
            end
            DONE: begin
                // Holding here rather than in IDLE keeps a held instruction from re-issuing.
                readdataM = resultReg;
                if (~pipe_stallM | flushM) nextState = IDLE;
            end
            CANCEL: begin
                stall_reqM = 1'b1;
                if (data_data_ok) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            resultReg <= '0;
        end else begin
            state <= nextState;
            if (capture) resultReg <= loadVal;
            if ((state == WAIT_ADDR || state == WAIT_DATA) &&
                (nextState == WAIT_ADDR || nextState == WAIT_DATA))
                waitCnt <= expired ? waitCnt : waitCnt + CW'(1);
            else
                waitCnt <= '0;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, multi-cycle corner sequences and
// randomized accesses against an arithmetic reference model with an emulated bus slave.
module tb_mem_stage_lsu;
    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, pipe_stallM, flushM;
    logic [2:0]  memopM;
    logic [31:0] addrM, wdataM;
    logic [31:0] readdataM;
    logic        stall_reqM, adelM, adesM, bus_err;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int nChecks = 0;
    int nPass   = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          addrDly;
        int          dataDly;
        int          postStall;
        logic [31:0] expRead;
        logic [31:0] expWdata;
        logic        expAdel;
        logic        expAdes;
        int          expStall;
    } vec_t;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memopM(memopM), .addrM(addrM),
        .wdataM(wdataM), .pipe_stallM(pipe_stallM), .flushM(flushM),
        .readdataM(readdataM), .stall_reqM(stall_reqM), .adelM(adelM), .adesM(adesM),
        .bus_err(bus_err), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // reference model
    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        longint f, m;
        int n;
        n = nbytes(op);
        if (op >= 3'd5) return 32'h0;
        m = longint'(1) << (8 * n);
        f = (longint'(rdata) >> (8 * (addr % 4))) % m;
        if ((op == 3'd0 || op == 3'd2) && f >= m / 2) f = f - m;
        return f[31:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] op, input logic [31:0] wdata);
        case (nbytes(op))
            1:       return (wdata % 256) * 32'h0101_0101;
            2:       return (wdata % 65536) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ad, input int dd, input int ps,
                                input logic [31:0] er, input logic [31:0] ew, input logic el,
                                input logic es, input int st);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.addrDly = ad; v.dataDly = dd; v.postStall = ps;
        v.expRead = er; v.expWdata = ew; v.expAdel = el; v.expAdes = es; v.expStall = st;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver + slave emulation for one instruction; entered and left on a negedge
    task automatic runInstr(input vec_t v, input string tag);
        int cyc, reqSeen, accepts, stalls, sinceAcc, stallLeft;
        bit accepted, responded, retired, mis, reqNow;
        cyc = 0; reqSeen = 0; accepts = 0; stalls = 0; sinceAcc = 0; stallLeft = 0;
        accepted = 0; responded = 0; retired = 0;
        mis = v.expAdel | v.expAdes;
        memenM = 1'b1; memopM = v.op; addrM = v.addr; wdataM = v.wdata; flushM = 1'b0;
        if (!mis) expQ.push_back(v.expRead);
        while (!retired && cyc < 64) begin
            #1;
            data_addr_ok = !accepted && data_req && (reqSeen == v.addrDly);
            data_data_ok = accepted && !responded && (sinceAcc == v.dataDly);
            data_rdata   = data_data_ok ? v.rdata : $urandom;
            pipe_stallM  = data_data_ok ? (v.postStall > 0) : (stallLeft > 0);
            #1;
            reqNow = data_req;
            if (cyc == 0) begin
                check({tag, " adelM"}, adelM, v.expAdel);
                check({tag, " adesM"}, adesM, v.expAdes);
            end
            if (mis) begin
                check({tag, " no_req"}, data_req, 1'b0);
                check({tag, " readdataM"}, readdataM, 32'h0);
            end
            if (reqNow && reqSeen == 0 && !accepted) begin
                check({tag, " data_wr"}, data_wr, v.op >= 3'd5);
                check({tag, " data_size"}, data_size, $clog2(nbytes(v.op)));
                check({tag, " data_addr"}, data_addr, v.addr);
                if (v.op >= 3'd5) check({tag, " data_wdata"}, data_wdata, v.expWdata);
            end
            if (data_data_ok || responded) begin
                check({tag, " readdataM"}, readdataM, expQ[0]);
                if (responded) check({tag, " no_reissue"}, data_req, 1'b0);
            end
            if (stall_reqM) stalls++;
            if (reqNow && data_addr_ok) accepts++;
            retired = !stall_reqM && !pipe_stallM;
            @(posedge clk);
            if (reqNow && !data_addr_ok && !accepted) reqSeen++;
            if (data_addr_ok) accepted = 1;
            if (accepted && !responded) sinceAcc++;
            if (data_data_ok) begin
                responded = 1;
                stallLeft = (v.postStall > 0) ? v.postStall - 1 : 0;
            end else if (stallLeft > 0) begin
                stallLeft--;
            end
            cyc++;
            @(negedge clk);
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; pipe_stallM = 1'b0;
        check({tag, " retired"}, retired, 1'b1);
        check({tag, " stall_cycles"}, stalls, v.expStall);
        check({tag, " accepts"}, accepts, mis ? 0 : 1);
        check({tag, " responded"}, responded, !mis);
        if (!mis && expQ.size() > 0) void'(expQ.pop_front());
    endtask

    initial begin
        vec_t tbl[16];
        int errCyc, errCnt;

        tbl[0]  = mk(3'd4, 32'h100, 32'h0,        32'h8badf00d, 0, 1, 0, 32'h8badf00d, 32'h0,        0, 0, 1);
        tbl[1]  = mk(3'd0, 32'h103, 32'h0,        32'h80123456, 0, 1, 0, 32'hffffff80, 32'h0,        0, 0, 1);
        tbl[2]  = mk(3'd1, 32'h103, 32'h0,        32'h80123456, 0, 1, 0, 32'h00000080, 32'h0,        0, 0, 1);
        tbl[3]  = mk(3'd2, 32'h102, 32'h0,        32'hfffe1234, 0, 1, 0, 32'hfffffffe, 32'h0,        0, 0, 1);
        tbl[4]  = mk(3'd3, 32'h102, 32'h0,        32'hfffe1234, 0, 1, 0, 32'h0000fffe, 32'h0,        0, 0, 1);
        tbl[5]  = mk(3'd0, 32'h101, 32'h0,        32'h12347f56, 0, 1, 0, 32'h0000007f, 32'h0,        0, 0, 1);
        tbl[6]  = mk(3'd2, 32'h100, 32'h0,        32'h12348001, 0, 1, 0, 32'hffff8001, 32'h0,        0, 0, 1);
        tbl[7]  = mk(3'd5, 32'h201, 32'h12345678, 32'h0,        0, 1, 0, 32'h0,        32'h78787878, 0, 0, 1);
        tbl[8]  = mk(3'd6, 32'h202, 32'h12345678, 32'h0,        0, 1, 0, 32'h0,        32'h56785678, 0, 0, 1);
        tbl[9]  = mk(3'd7, 32'h204, 32'h12345678, 32'h0,        0, 1, 0, 32'h0,        32'h12345678, 0, 0, 1);
        tbl[10] = mk(3'd4, 32'h102, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        1, 0, 0);
        tbl[11] = mk(3'd6, 32'h003, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 0);
        tbl[12] = mk(3'd3, 32'h101, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        1, 0, 0);
        tbl[13] = mk(3'd7, 32'h206, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 0);
        tbl[14] = mk(3'd4, 32'h108, 32'h0,        32'hcafebabe, 3, 2, 2, 32'hcafebabe, 32'h0,        0, 0, 5);
        tbl[15] = mk(3'd1, 32'h102, 32'h0,        32'haabbccdd, 1, 3, 1, 32'h000000bb, 32'h0,        0, 0, 4);

        rst = 1'b1; memenM = 1'b0; memopM = 3'd4; addrM = 32'h0000_1234; wdataM = 32'hdead_beef;
        pipe_stallM = 1'b0; flushM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (3) step();
        #2;
        check("reset data_req", data_req, 1'b0);
        check("reset data_addr", data_addr, 32'h0);
        check("reset data_wdata", data_wdata, 32'h0);
        rst = 1'b0;
        step();
        #2;
        check("idle data_req", data_req, 1'b0);
        check("idle stall_reqM", stall_reqM, 1'b0);
        check("idle readdataM", readdataM, 32'h0);
        check("idle bus_err", bus_err, 1'b0);
        check("idle data_wr", data_wr, 1'b0);
        check("idle data_size", data_size, 2'd0);
        check("idle adel/ades", {adelM, adesM}, 2'b00);
        @(negedge clk);

        for (int i = 0; i < 16; i++) runInstr(tbl[i], $sformatf("vec%0d", i));

        // flush while waiting for data: CANCEL swallows the late response, next load still works
        memenM = 1'b1; memopM = 3'd4; addrM = 32'h100; flushM = 1'b0; data_addr_ok = 1'b1;
        #2; check("cancel issue req", data_req, 1'b1);
        step();
        data_addr_ok = 1'b0; flushM = 1'b1;
        #2; check("cancel flush stall", stall_reqM, 1'b1);
        step();
        flushM = 1'b0; addrM = 32'h200;
        #2;
        check("cancel stall", stall_reqM, 1'b1);
        check("cancel no req", data_req, 1'b0);
        step();
        data_data_ok = 1'b1; data_rdata = 32'hdeadbeef;
        #2;
        check("cancel swallow readdataM", readdataM, 32'h0);
        check("cancel swallow stall", stall_reqM, 1'b1);
        check("cancel swallow no req", data_req, 1'b0);
        step();
        data_data_ok = 1'b0;
        runInstr(mk(3'd4, 32'h200, 32'h0, 32'h0badcafe, 0, 1, 0, 32'h0badcafe, 32'h0, 0, 0, 1), "after_cancel");

        // flush in WAIT_ADDR without acceptance: straight back to IDLE
        memenM = 1'b1; memopM = 3'd4; addrM = 32'h300;
        #2; check("fwa issue req", data_req, 1'b1);
        step();
        flushM = 1'b1;
        #2; check("fwa held req", data_req, 1'b1);
        step();
        flushM = 1'b0; memenM = 1'b0;
        #2;
        check("fwa idle stall", stall_reqM, 1'b0);
        check("fwa idle req", data_req, 1'b0);
        @(negedge clk);

        // flush in WAIT_ADDR with acceptance the same cycle: CANCEL waits for data_ok
        memenM = 1'b1; addrM = 32'h304;
        step();
        flushM = 1'b1; data_addr_ok = 1'b1;
        step();
        flushM = 1'b0; data_addr_ok = 1'b0; memenM = 1'b0; data_data_ok = 1'b1;
        #2;
        check("fwa_acc cancel stall", stall_reqM, 1'b1);
        check("fwa_acc cancel req", data_req, 1'b0);
        step();
        data_data_ok = 1'b0;
        #2; check("fwa_acc idle stall", stall_reqM, 1'b0);
        @(negedge clk);

        // silent slave: watchdog fires once and returns to IDLE
        errCyc = -1; errCnt = 0;
        memenM = 1'b1; memopM = 3'd4; addrM = 32'h400;
        for (int c = 0; c < MAX_WAIT + 20; c++) begin
            #2;
            if (bus_err) begin
                errCnt++;
                if (errCyc < 0) errCyc = c;
            end
            step();
            if (errCyc >= 0) memenM = 1'b0;
        end
        check("wd pulse count", errCnt, 1);
        check("wd expiry cycle", errCyc, MAX_WAIT + 1);
        #2;
        check("wd idle req", data_req, 1'b0);
        check("wd idle stall", stall_reqM, 1'b0);
        @(negedge clk);

        // reset in the middle of an access
        memenM = 1'b1; memopM = 3'd4; addrM = 32'h500; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; memenM = 1'b0;
        #2;
        check("midrst stall", stall_reqM, 1'b0);
        check("midrst req", data_req, 1'b0);
        check("midrst readdataM", readdataM, 32'h0);
        @(negedge clk);
        runInstr(mk(3'd2, 32'h502, 32'h0, 32'h9abc0000, 0, 1, 0, 32'hffff9abc, 32'h0, 0, 0, 1), "after_rst");

        // randomized accesses against the reference model
        for (int i = 0; i < 120; i++) begin
            vec_t v;
            int n;
            bit mis;
            v.op = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            n = nbytes(v.op);
            if ($urandom_range(0, 2) != 0) v.addr = v.addr - (v.addr % n);
            v.wdata = $urandom; v.rdata = $urandom;
            v.addrDly = $urandom_range(0, 4); v.dataDly = $urandom_range(1, 4);
            v.postStall = $urandom_range(0, 2);
            mis = (v.addr % n) != 0;
            v.expAdel = mis && v.op < 3'd5;
            v.expAdes = mis && v.op >= 3'd5;
            v.expRead = modelRead(v.op, v.addr, v.rdata);
            v.expWdata = modelWdata(v.op, v.wdata);
            v.expStall = mis ? 0 : v.addrDly + v.dataDly;
            if ($urandom_range(0, 4) == 0) begin
                memenM = 1'b0;
                #2;
                check($sformatf("rnd%0d bubble req", i), data_req, 1'b0);
                check($sformatf("rnd%0d bubble stall", i), stall_reqM, 1'b0);
                @(negedge clk);
            end
            runInstr(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
